// File: rtl/iob_native_ram_resp.sv
// IOb native bus responder backed by a byte-writable synchronous RAM with programmable
// read latency and write wait states. Optional counters: IOB_NATIVE_RAM_RESP_STATS_EN.
module iob_native_ram_resp #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int WR_WAIT  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o
`ifdef IOB_NATIVE_RAM_RESP_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [15:0]         rd_cnt_o,
  output logic [15:0]         wr_cnt_o
`endif
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RBUSY, WBUSY} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              rvalid_nxt;
  logic              rd_acc, wr_acc;
  logic              is_wr;
  logic [ADDR_W-3:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_addr_lsb;

  assign is_wr           = |iob_wstrb_i;
  assign idx             = iob_addr_i[ADDR_W-1:2];
  assign unused_addr_lsb = ^iob_addr_i[1:0];

  // rd_acc/wr_acc mean "accepted if this edge is enabled"; the registers apply cke_i/rst_i.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rvalid_nxt  = 1'b0;
    rd_acc      = 1'b0;
    wr_acc      = 1'b0;
    iob_ready_o = 1'b0;
    unique case (state)
      IDLE: begin
        iob_ready_o = ~iob_avalid_i | ~is_wr | (WR_WAIT == 0);
        if (iob_avalid_i) begin
          if (!is_wr) begin
            rd_acc = 1'b1;
          end else if (WR_WAIT == 0) begin
            wr_acc = 1'b1;
          end else begin
            state_nxt = WBUSY;
            cnt_nxt   = 4'(WR_WAIT - 1);
          end
        end
      end
      WBUSY: begin
        iob_ready_o = (cnt == '0);
        if (!iob_avalid_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (is_wr) begin
          wr_acc    = 1'b1;
          state_nxt = IDLE;
        end else begin
          rd_acc = 1'b1;
        end
      end
      RBUSY: begin
        // rvalid is registered, so it is launched one count early to land at READ_LAT.
        if (cnt == 4'd1) begin
          rvalid_nxt = 1'b1;
          state_nxt  = IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (rd_acc) begin
      if (READ_LAT == 1) begin
        rvalid_nxt = 1'b1;
        state_nxt  = IDLE;
      end else begin
        state_nxt = RBUSY;
        cnt_nxt   = 4'(READ_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      iob_rvalid_o <= 1'b0;
      iob_rdata_o  <= '0;
    end else if (cke_i) begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      iob_rvalid_o <= rvalid_nxt;
      if (rd_acc) iob_rdata_o <= mem[idx];
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (cke_i && !rst_i && wr_acc) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (iob_wstrb_i[b]) mem[idx][8*b +: 8] <= iob_wdata_i[8*b +: 8];
      end
    end
  end

`ifdef IOB_NATIVE_RAM_RESP_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (cke_i) begin
      if (stats_clr_i) begin
        rd_cnt_o <= '0;
        wr_cnt_o <= '0;
      end else begin
        if (rd_acc && rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + 16'd1;
        if (wr_acc && wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_iob_native_ram_resp.sv
// Scoreboard bench for iob_native_ram_resp: three latency/wait configurations run side by side,
// each with a random driver, a memory/timing reference model and an independent rvalid monitor.
module tb_iob_native_ram_resp;

  localparam int AW   = 8;
  localparam int NW   = 2 ** (AW - 2);
  localparam int NCFG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done [NCFG];

  typedef struct {
    logic [31:0] data;
    int          due;
  } rexp_t;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int ww_of(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d: got %h expected %h at %0t", nm, g, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int LAT = lat_of(g);
    localparam int WW  = ww_of(g);

    logic          rst    = 1'b1;
    logic          cke    = 1'b1;
    logic          avalid = 1'b0;
    logic [AW-1:0] addr   = '0;
    logic [31:0]   wdata  = '0;
    logic [3:0]    wstrb  = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic          rvalid;

    int          en_cyc    = 0;   // count of enabled clock edges
    int          next_free = 0;   // first enabled cycle in which a new request may be taken
    logic [31:0] mdl [NW];
    rexp_t       q [$];
    int          n_rd = 0;
    int          n_wr = 0;
`ifdef IOB_NATIVE_RAM_RESP_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;
`endif

    iob_native_ram_resp #(
      .ADDR_W  (AW),
      .DATA_W  (32),
      .READ_LAT(LAT),
      .WR_WAIT (WW)
    ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cke_i       (cke),
      .iob_avalid_i(avalid),
      .iob_addr_i  (addr),
      .iob_wdata_i (wdata),
      .iob_wstrb_i (wstrb),
      .iob_rdata_o (rdata),
      .iob_ready_o (ready),
      .iob_rvalid_o(rvalid)
`ifdef IOB_NATIVE_RAM_RESP_STATS_EN
      ,
      .stats_clr_i (1'b0),
      .rd_cnt_o    (rd_cnt),
      .wr_cnt_o    (wr_cnt)
`endif
    );

    always @(posedge clk) if (cke) en_cyc <= en_cyc + 1;

    // Present one request and hold it until the model says it is taken (or abandon a write).
    task automatic req(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit may_drop);
      int start;
      int c;
      bit accepted;
      bit er;
      start    = -1;
      accepted = 1'b0;
      while (!accepted) begin
        @(posedge clk); #1;
        avalid = 1'b1;
        addr   = a;
        wdata  = d;
        wstrb  = wr ? s : 4'h0;
        cke    = ($urandom_range(0, 7) != 0);
        @(negedge clk);
        c = en_cyc;
        if (c >= next_free && start < 0) start = c;
        er = (c >= next_free) && (!wr || (c - start >= WW));
        chk("ready", g, 32'(ready), 32'(er));
        if (er && cke) begin
          accepted = 1'b1;
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (s[b]) mdl[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
            n_wr++;
          end else begin
            q.push_back('{data: mdl[a[AW-1:2]], due: c + LAT});
            next_free = c + LAT;
            n_rd++;
          end
        end else if (wr && may_drop && start >= 0 && c > start && cke &&
                     $urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          avalid = 1'b0;
          wstrb  = 4'h0;
          cke    = 1'b1;
          return;
        end
      end
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk); #1;
        avalid = 1'b0;
        wstrb  = 4'h0;
        cke    = ($urandom_range(0, 3) != 0);
      end
    endtask

    // A read is in flight when reset arrives: it must never complete.
    task automatic rst_during_read(input logic [AW-1:0] a);
      req(1'b0, a, 32'h0, 4'h0, 1'b0);
      @(posedge clk); #1;
      avalid = 1'b0;
      cke    = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1;
      rst       = 1'b0;
      next_free = en_cyc;
      n_rd      = 0;
      n_wr      = 0;
      @(negedge clk);
      chk("rdata_after_rst", g, rdata, 32'h0);
    endtask

    initial begin : monitor
      bit exp_rv;
      forever begin
        @(negedge clk);
        exp_rv = (q.size() > 0) && (q[0].due == en_cyc);
        if (cke) begin
          chk("rvalid", g, 32'(rvalid), 32'(exp_rv));
          if (exp_rv) begin
            if (rvalid) chk("rdata", g, rdata, q[0].data);
            void'(q.pop_front());
          end
        end
      end
    end

    initial begin : driver
      logic [AW-1:0] ra;
      bit            rw;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      next_free = en_cyc;
      @(negedge clk);
      chk("rdata_rst", g, rdata, 32'h0);

      for (int i = 0; i < NW; i++) req(1'b1, AW'(i * 4), $urandom, 4'hF, 1'b0);

      req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      req(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
      req(1'b1, 8'h20, 32'h0, 4'hF, 1'b0);
      req(1'b1, 8'h20, 32'h11223344, 4'h2, 1'b0);
      req(1'b0, 8'h20, 32'h0, 4'h0, 1'b0);
      idle(1);
      req(1'b0, 8'h00, 32'h0, 4'h0, 1'b0);
      req(1'b0, 8'h04, 32'h0, 4'h0, 1'b0);
      idle(LAT + 1);

      if (LAT >= 3) begin
        rst_during_read(8'h10);
        req(1'b0, 8'h10, 32'h0, 4'h0, 1'b0);
      end

      repeat (250) begin
        idle($urandom_range(0, 2));
        rw = $urandom_range(0, 1) == 1;
        ra = AW'($urandom_range(0, 2 ** AW - 1));
        req(rw, ra, $urandom, 4'($urandom_range(1, 15)), 1'b1);
      end

      repeat (LAT + 3) begin
        @(posedge clk); #1;
        avalid = 1'b0;
        wstrb  = 4'h0;
        cke    = 1'b1;
      end
      @(negedge clk);
      chk("queue_drained", g, 32'(q.size()), 32'h0);
`ifdef IOB_NATIVE_RAM_RESP_STATS_EN
      chk("rd_cnt", g, 32'(rd_cnt), 32'(n_rd));
      chk("wr_cnt", g, 32'(wr_cnt), 32'(n_wr));
`endif
      done[g] = 1'b1;
    end
  end

  initial begin : summary
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 60000) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d%0d%0d done flags, expected 111", done[0], done[1], done[2]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
